// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the dual-slot issue scoreboard: opcode classes,
// FSM state type and per-field decode helpers.
package issue_pkg;

  localparam int REG_W = 3;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_SYNC = 4'hE;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic logic writes_rd(input logic [3:0] op);
    return !(op == OP_NOP || op == OP_ST || op == OP_BR || op == OP_SYNC);
  endfunction

  function automatic logic reads_rs1(input logic [3:0] op);
    return !(op == OP_NOP || op == OP_SYNC);
  endfunction

  // Register-form instructions only; NOP and SYNC never read a source.
  function automatic logic reads_rs2(input logic [3:0] op, input logic imm);
    return !imm && reads_rs1(op);
  endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Fetch/writeback side bundle of the issue scoreboard. master = fetch/decode
// driver, slave = scoreboard.
interface issue_scoreboard_if #(
  parameter int NREG = 8,
  parameter int IW   = 16,
  parameter int NWB  = 2
);
  localparam int RW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic [1:0]        in_valid;
  logic [IW-1:0]     instr0;
  logic [IW-1:0]     instr1;
  logic [NWB-1:0]    wb_valid;
  logic [RW*NWB-1:0] wb_rd;
  logic              flush;
  logic [1:0]        grant;
  logic              stall;
  logic [NREG-1:0]   busy;
  logic [CW-1:0]     inflight;
  logic              err_wb_idle;

  modport master (
    output in_valid, instr0, instr1, wb_valid, wb_rd, flush,
    input  grant, stall, busy, inflight, err_wb_idle
  );

  modport slave (
    input  in_valid, instr0, instr1, wb_valid, wb_rd, flush,
    output grant, stall, busy, inflight, err_wb_idle
  );

endinterface

// File: rtl/issue_scoreboard_hazard.sv
// issue_hazard_check: decodes one instruction slot and flags a RAW/WAW
// conflict against the supplied busy vector.
module issue_hazard_check
  import issue_pkg::*;
#(
  parameter int NREG = 8,
  parameter int IW   = 16
) (
  input  logic [NREG-1:0]  busy_i,
  input  logic [IW-1:0]    instr_i,
  output logic             hz_o,
  output logic             wr_o,
  output logic             rs1_rd_o,
  output logic             rs2_rd_o,
  output logic             sync_o,
  output logic             br_o,
  output logic [REG_W-1:0] rd_o,
  output logic [REG_W-1:0] rs1_o,
  output logic [REG_W-1:0] rs2_o
);

  logic [3:0] op;
  logic       imm;
  logic       unused_lsb;

  assign op         = instr_i[15:12];
  assign imm        = instr_i[11];
  assign rd_o       = instr_i[10:8];
  assign rs1_o      = instr_i[7:5];
  assign rs2_o      = instr_i[4:2];
  assign unused_lsb = ^instr_i[1:0];

  assign wr_o     = writes_rd(op);
  assign rs1_rd_o = reads_rs1(op);
  assign rs2_rd_o = reads_rs2(op, imm);
  assign sync_o   = (op == OP_SYNC);
  assign br_o     = (op == OP_BR);

  assign hz_o = (rs1_rd_o & busy_i[rs1_o])
              | (rs2_rd_o & busy_i[rs2_o])
              | (wr_o     & busy_i[rd_o]);

endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: dual-slot issue control with a per-register busy scoreboard,
// SYNC drain and branch-flush bubble. Define WB_BYPASS_EN to let a same-cycle
// writeback release a dependent instruction.
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter int NREG = 8,
  parameter int IW   = 16,
  parameter int NWB  = 2
) (
  input logic               clk,
  input logic               reset,
  issue_scoreboard_if.slave bus
);

  localparam int CW = $clog2(NREG + 1);

  state_e            state_q, state_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              err_q, err_d;
  logic [NREG-1:0]   wbclr;
  logic [NREG-1:0]   set_v;
  logic [NREG-1:0]   hz_busy;
  logic              wb_idle;
  logic [1:0]        grant;
  logic              pair_dep;
  logic [CW-1:0]     cnt;

  logic              hz0, wr0, sync0, br0;
  logic [REG_W-1:0]  rd0;
  logic              hz1, wr1, rs1rd1, rs2rd1;
  logic [REG_W-1:0]  rd1, rs1_1, rs2_1;
  logic              unused_rs1rd0, unused_rs2rd0, unused_sync1, unused_br1;
  logic [REG_W-1:0]  unused_rs1_0, unused_rs2_0;

  always_comb begin
    wbclr   = '0;
    wb_idle = 1'b0;
    for (int k = 0; k < NWB; k++) begin
      if (bus.wb_valid[k]) begin
        wbclr[bus.wb_rd[REG_W*k +: REG_W]] = 1'b1;
        if (!busy_q[bus.wb_rd[REG_W*k +: REG_W]]) wb_idle = 1'b1;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign hz_busy = busy_q & ~wbclr;
`else
  assign hz_busy = busy_q;
`endif

  issue_hazard_check #(.NREG(NREG), .IW(IW)) u_hz0 (
    .busy_i   (hz_busy),
    .instr_i  (bus.instr0),
    .hz_o     (hz0),
    .wr_o     (wr0),
    .rs1_rd_o (unused_rs1rd0),
    .rs2_rd_o (unused_rs2rd0),
    .sync_o   (sync0),
    .br_o     (br0),
    .rd_o     (rd0),
    .rs1_o    (unused_rs1_0),
    .rs2_o    (unused_rs2_0)
  );

  issue_hazard_check #(.NREG(NREG), .IW(IW)) u_hz1 (
    .busy_i   (hz_busy),
    .instr_i  (bus.instr1),
    .hz_o     (hz1),
    .wr_o     (wr1),
    .rs1_rd_o (rs1rd1),
    .rs2_rd_o (rs2rd1),
    .sync_o   (unused_sync1),
    .br_o     (unused_br1),
    .rd_o     (rd1),
    .rs1_o    (rs1_1),
    .rs2_o    (rs2_1)
  );

  // Issue decision and FSM next state; flush overrides every other transition.
  always_comb begin
    state_d  = state_q;
    grant    = 2'b00;
    pair_dep = wr0 && ((rs1rd1 && rs1_1 == rd0) ||
                       (rs2rd1 && rs2_1 == rd0) ||
                       (wr1    && rd1   == rd0));
    if (!reset && state_q == RUN && !bus.flush && bus.in_valid[0] && !hz0)
      grant[0] = sync0 ? (busy_q == '0) : 1'b1;
    grant[1] = grant[0] & bus.in_valid[1] & ~hz1 & ~sync0 & ~br0 & ~pair_dep;

    case (state_q)
      RUN:     if (bus.in_valid[0] && sync0 && busy_q != '0) state_d = DRAIN;
      DRAIN:   if (busy_q == '0) state_d = RUN;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
    if (bus.flush) state_d = FLUSH;
  end

  // A register issued and written back in the same cycle stays busy.
  always_comb begin
    set_v = '0;
    if (grant[0] && wr0) set_v[rd0] = 1'b1;
    if (grant[1] && wr1) set_v[rd1] = 1'b1;
    busy_d = (busy_q & ~wbclr) | set_v;
    err_d  = err_q | wb_idle;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      busy_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    cnt = '0;
    for (int r = 0; r < NREG; r++) cnt = cnt + CW'(busy_q[r]);
  end

  assign bus.grant       = grant;
  assign bus.stall       = ~reset & bus.in_valid[0] & ~grant[0];
  assign bus.busy        = busy_q;
  assign bus.inflight    = cnt;
  assign bus.err_wb_idle = err_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios followed by random traffic,
// all checked cycle by cycle against a pending-write reference model.
module tb_issue_scoreboard;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_FLUSH = 2;

  localparam logic [3:0] ADD = 4'h1;
  localparam logic [3:0] SUB = 4'h2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  issue_scoreboard_if #(.NREG(8), .IW(16), .NWB(2)) bus ();

  issue_scoreboard #(.NREG(8), .IW(16), .NWB(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests;
  int n_fail;

  bit   pend [8];
  int   mode;
  bit   err_m;
  logic [1:0] g_obs;
  logic       s_obs;

  logic [3:0] ops [8] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h0, 4'hB, 4'hC, 4'hE};

  function automatic logic [15:0] mk(input logic [3:0] op, input bit imm,
                                     input int rd, input int rs1, input int rs2);
    return {op, imm, 3'(rd), 3'(rs1), 3'(rs2), 2'b00};
  endfunction

  function automatic bit m_writes(input logic [15:0] in);
    return !(in[15:12] inside {4'h0, 4'hB, 4'hC, 4'hE});
  endfunction

  function automatic bit m_rs1(input logic [15:0] in);
    return !(in[15:12] inside {4'h0, 4'hE});
  endfunction

  function automatic bit m_rs2(input logic [15:0] in);
    return !in[11];
  endfunction

  function automatic bit m_pending(input int r, input logic [1:0] wv, input logic [5:0] wr);
    bit cleared;
    cleared = (wv[0] && int'(wr[2:0]) == r) || (wv[1] && int'(wr[5:3]) == r);
    return pend[r] && !(BYP && cleared);
  endfunction

  function automatic bit m_hz(input logic [15:0] in, input logic [1:0] wv, input logic [5:0] wr);
    return (m_rs1(in)    && m_pending(int'(in[7:5]), wv, wr)) ||
           (m_rs2(in)    && m_pending(int'(in[4:2]), wv, wr)) ||
           (m_writes(in) && m_pending(int'(in[10:8]), wv, wr));
  endfunction

  function automatic bit dep(input logic [15:0] a, input logic [15:0] b);
    if (!m_writes(a)) return 1'b0;
    return (m_rs1(b) && b[7:5] == a[10:8]) ||
           (m_rs2(b) && b[4:2] == a[10:8]) ||
           (m_writes(b) && b[10:8] == a[10:8]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] v, input logic [15:0] i0, input logic [15:0] i1,
                      input logic [1:0] wv, input logic [5:0] wr, input bit fl);
    bit any, e0, e1, es, s0;
    int nb;
    logic [7:0] bv;
    @(negedge clk);
    bus.in_valid = v;
    bus.instr0   = i0;
    bus.instr1   = i1;
    bus.wb_valid = wv;
    bus.wb_rd    = wr;
    bus.flush    = fl;
    #1;
    nb = 0;
    bv = '0;
    for (int r = 0; r < 8; r++) if (pend[r]) begin nb++; bv[r] = 1'b1; end
    any = (nb != 0);
    s0  = (i0[15:12] == 4'hE);
    e0  = 1'b0;
    if (mode == M_RUN && !fl && v[0]) e0 = s0 ? !any : !m_hz(i0, wv, wr);
    e1 = e0 && v[1] && !m_hz(i1, wv, wr) && !s0 && (i0[15:12] != 4'hC) && !dep(i0, i1);
    es = v[0] && !e0;
    g_obs = bus.grant;
    s_obs = bus.stall;
    chk("grant", 32'(bus.grant), 32'({e1, e0}));
    chk("stall", 32'(bus.stall), 32'(es));
    chk("busy", 32'(bus.busy), 32'(bv));
    chk("inflight", 32'(bus.inflight), 32'(nb));
    chk("err_wb_idle", 32'(bus.err_wb_idle), 32'(err_m));
    @(posedge clk);
    for (int k = 0; k < 2; k++) if (wv[k] && !pend[wr[3*k +: 3]]) err_m = 1'b1;
    for (int k = 0; k < 2; k++) if (wv[k]) pend[wr[3*k +: 3]] = 1'b0;
    if (e0 && m_writes(i0)) pend[i0[10:8]] = 1'b1;
    if (e1 && m_writes(i1)) pend[i1[10:8]] = 1'b1;
    if (fl)                   mode = M_FLUSH;
    else if (mode == M_FLUSH) mode = M_RUN;
    else if (mode == M_DRAIN) mode = any ? M_DRAIN : M_RUN;
    else if (v[0] && s0 && any) mode = M_DRAIN;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 2'b11;
    bus.instr0   = mk(ADD, 0, 1, 2, 3);
    bus.instr1   = mk(ADD, 0, 4, 5, 6);
    bus.wb_valid = 2'b00;
    bus.wb_rd    = '0;
    bus.flush    = 1'b0;
    #1;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_inflight", 32'(bus.inflight), 32'd0);
    chk("rst_err", 32'(bus.err_wb_idle), 32'd0);
    reset = 1'b0;
    for (int r = 0; r < 8; r++) pend[r] = 1'b0;
    mode  = M_RUN;
    err_m = 1'b0;
  endtask

  function automatic logic [15:0] rnd_instr();
    logic [3:0] op;
    bit imm;
    op  = ops[$urandom_range(0, 7)];
    imm = (op == 4'h0 || op == 4'hE) ? 1'b1 : 1'($urandom_range(0, 1));
    return mk(op, imm, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
  endfunction

  function automatic logic [2:0] pick();
    int q[$];
    for (int r = 0; r < 8; r++) if (pend[r]) q.push_back(r);
    if (q.size() > 0 && $urandom_range(0, 99) < 90) return 3'(q[$urandom_range(0, q.size() - 1)]);
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [15:0] nop, sy, x, p0, p1, raw, rawp;
    n_tests = 0;
    n_fail  = 0;
    mode    = M_RUN;
    err_m   = 1'b0;
    bus.in_valid = 2'b00;
    bus.instr0   = '0;
    bus.instr1   = '0;
    bus.wb_valid = 2'b00;
    bus.wb_rd    = '0;
    bus.flush    = 1'b0;
    nop  = mk(4'h0, 1, 0, 0, 0);
    sy   = mk(4'hE, 1, 0, 0, 0);
    x    = mk(ADD, 0, 6, 1, 1);
    p0   = mk(ADD, 0, 1, 2, 3);
    p1   = mk(ADD, 0, 4, 5, 6);
    raw  = mk(SUB, 0, 3, 2, 0);
    rawp = mk(SUB, 0, 5, 3, 1);

    do_reset();

    step(2'b11, p0, p1, 2'b00, 6'd0, 0);
    chk("pair_grant", 32'(g_obs), 32'b11);
    #1;
    chk("pair_busy", 32'(bus.busy), 32'h12);
    chk("pair_inflight", 32'(bus.inflight), 32'd2);

    step(2'b01, mk(ADD, 0, 2, 0, 0), nop, 2'b00, 6'd0, 0);
    chk("set_r2_grant", 32'(g_obs), 32'b01);
    step(2'b01, raw, nop, 2'b00, 6'd0, 0);
    chk("raw_grant", 32'(g_obs), 32'b00);
    chk("raw_stall", 32'(s_obs), 32'd1);
    step(2'b01, raw, nop, 2'b01, 6'd2, 0);
    chk("raw_wb_cycle", 32'(g_obs), BYP ? 32'b01 : 32'b00);
    step(2'b01, raw, nop, 2'b00, 6'd0, 0);
    chk("raw_after_wb", 32'(g_obs), BYP ? 32'b00 : 32'b01);
    #1;
    chk("raw_busy", 32'(bus.busy), 32'h1A);
    step(2'b00, nop, nop, 2'b11, {3'd4, 3'd1}, 0);
    step(2'b00, nop, nop, 2'b01, 6'd3, 0);
    #1;
    chk("clear_busy", 32'(bus.busy), 32'h00);

    step(2'b11, mk(ADD, 0, 3, 0, 0), rawp, 2'b00, 6'd0, 0);
    chk("intra_grant", 32'(g_obs), 32'b01);
    step(2'b01, rawp, nop, 2'b00, 6'd0, 0);
    chk("intra_wait", 32'(g_obs), 32'b00);
    step(2'b01, rawp, nop, 2'b01, 6'd3, 0);
    chk("intra_wb_cycle", 32'(g_obs), BYP ? 32'b01 : 32'b00);
    step(2'b01, rawp, nop, 2'b00, 6'd0, 0);
    chk("intra_after_wb", 32'(g_obs), BYP ? 32'b00 : 32'b01);
    #1;
    chk("intra_busy", 32'(bus.busy), 32'h20);
    step(2'b00, nop, nop, 2'b01, 6'd5, 0);

    step(2'b11, mk(ADD, 0, 0, 1, 1), mk(ADD, 0, 2, 1, 1), 2'b00, 6'd0, 0);
    #1;
    chk("sync_pre_busy", 32'(bus.busy), 32'h05);
    step(2'b11, sy, x, 2'b00, 6'd0, 0);
    chk("sync_hold", 32'(g_obs), 32'b00);
    chk("sync_stall", 32'(s_obs), 32'd1);
    step(2'b11, sy, x, 2'b11, {3'd2, 3'd0}, 0);
    chk("drain_grant", 32'(g_obs), 32'b00);
    #1;
    chk("drain_busy", 32'(bus.busy), 32'h00);
    step(2'b11, sy, x, 2'b00, 6'd0, 0);
    chk("drain_exit", 32'(g_obs), 32'b00);
    step(2'b11, sy, x, 2'b00, 6'd0, 0);
    chk("sync_alone", 32'(g_obs), 32'b01);

    step(2'b11, p0, p1, 2'b00, 6'd0, 1);
    chk("flush_c1", 32'(g_obs), 32'b00);
    step(2'b11, p0, p1, 2'b00, 6'd0, 0);
    chk("flush_c2", 32'(g_obs), 32'b00);
    step(2'b11, p0, p1, 2'b00, 6'd0, 0);
    chk("flush_c3", 32'(g_obs), 32'b11);
    step(2'b00, nop, nop, 2'b00, 6'd0, 1);
    #1;
    chk("flush_keeps_busy", 32'(bus.busy), 32'h12);
    step(2'b00, nop, nop, 2'b11, {3'd4, 3'd1}, 0);

    step(2'b00, nop, nop, 2'b01, 6'd7, 0);
    #1;
    chk("err_set", 32'(bus.err_wb_idle), 32'd1);
    chk("err_busy", 32'(bus.busy), 32'h00);
    step(2'b00, nop, nop, 2'b00, 6'd0, 0);
    #1;
    chk("err_sticky", 32'(bus.err_wb_idle), 32'd1);

    step(2'b01, mk(ADD, 0, 1, 2, 2), nop, 2'b00, 6'd0, 0);
    step(2'b01, sy, nop, 2'b00, 6'd0, 0);
    chk("drain_entry", 32'(g_obs), 32'b00);
    do_reset();
    step(2'b01, sy, nop, 2'b00, 6'd0, 0);
    chk("sync_after_reset", 32'(g_obs), 32'b01);
    step(2'b00, nop, nop, 2'b00, 6'd0, 1);
    do_reset();
    step(2'b11, p0, p1, 2'b00, 6'd0, 0);
    chk("run_after_flush_reset", 32'(g_obs), 32'b11);

    for (int c = 0; c < 600; c++) begin
      logic [1:0]  v, wv;
      logic [15:0] a, b;
      logic [5:0]  wr;
      bit          fl;
      v  = 2'($urandom_range(0, 3));
      a  = rnd_instr();
      b  = rnd_instr();
      wv = 2'b00;
      wr = '0;
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 99) < 55) begin
          wv[k]        = 1'b1;
          wr[3*k +: 3] = pick();
        end
      end
      fl = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 249) == 0) do_reset();
      else step(v, a, b, wv, wr, fl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
